// File: rtl/peaks_readout_bridge.sv
// peaks_readout_bridge
//   Takes each completed peak set from the sequential peak finder and serves
//   it to the HPS driver over an 8-bit Avalon-MM slave. The two banks work as
//   a ping-pong buffer, so software never reads a torn frame. Software must
//   acknowledge each frame. Overruns are counted, and irq is a level signal.
//
// Ports
//   clk            system clock
//   reset          synchronous, active-low reset
//   valid_in       one-cycle pulse: counter_in/freqs_in/amplitudes_in are valid
//   counter_in     frame time counter
//   freqs_in       peak i at [i*FREQ_WIDTH +: FREQ_WIDTH]
//   amplitudes_in  peak i at [i*AMPL_WIDTH +: AMPL_WIDTH]
//   chipselect, read, write, address, writedata   Avalon-MM slave inputs
//   readdata       registered read data, valid one cycle after the read strobe
//   irq            high while the front bank holds an unacknowledged frame
module peaks_readout_bridge #(
  parameter int PEAKS         = 6,
  parameter int FREQ_WIDTH    = 8,
  parameter int AMPL_WIDTH    = 24,
  parameter int COUNTER_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          valid_in,
  input  logic [COUNTER_WIDTH-1:0]      counter_in,
  input  logic [PEAKS*FREQ_WIDTH-1:0]   freqs_in,
  input  logic [PEAKS*AMPL_WIDTH-1:0]   amplitudes_in,
  input  logic                          chipselect,
  input  logic                          read,
  input  logic                          write,
  input  logic [7:0]                    address,
  input  logic [7:0]                    writedata,
  output logic [7:0]                    readdata,
  output logic                          irq
);

  if (AMPL_WIDTH > 24 || FREQ_WIDTH > 8 || COUNTER_WIDTH > 32 || PEAKS > 6) begin : g_param_check
    $error("peaks_readout_bridge: field widths exceed their register slots");
  end

  localparam logic [1:0] ST_EMPTY   = 2'd0;
  localparam logic [1:0] ST_READY   = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;

  logic [1:0] state_q, state_d;
  logic       fb_q, fb_d;
  logic [7:0] seq_ctr_q, seq_ctr_d;
  logic       ovf_sticky_q, ovf_sticky_d;
  logic [7:0] ovf_cnt_q, ovf_cnt_d;
  logic [7:0] readdata_q;
  logic       irq_q;

  // Bank storage is kept in flops because reset must clear it.
  logic [COUNTER_WIDTH-1:0] cnt_q  [2];
  logic [FREQ_WIDTH-1:0]    freq_q [2][PEAKS];
  logic [AMPL_WIDTH-1:0]    amp_q  [2][PEAKS];
  logic [7:0]               seq_q  [2];

  logic       ack, clr, ovf, wr_en, wr_bank;
  logic [1:0] st_a;
  logic       fb_a;
  logic [7:0] rd_byte;
  logic       unused_writedata;

  assign unused_writedata = ^writedata[7:2];

  assign ack = chipselect && write && (address == 8'hFF) && writedata[0];
  assign clr = chipselect && write && (address == 8'hFF) && writedata[1];

  always_comb begin
    // Apply the ack first. A capture in the same cycle then sees the post-ack state.
    st_a = state_q;
    fb_a = fb_q;
    if (ack) begin
      case (state_q)
        ST_READY:   st_a = ST_EMPTY;
        ST_PENDING: begin st_a = ST_READY; fb_a = ~fb_q; end
        default:    ;
      endcase
    end

    state_d      = st_a;
    fb_d         = fb_a;
    seq_ctr_d    = seq_ctr_q;
    ovf_sticky_d = ovf_sticky_q;
    ovf_cnt_d    = ovf_cnt_q;
    wr_en        = 1'b0;
    wr_bank      = fb_q;
    ovf          = 1'b0;

    if (valid_in) begin
      wr_en     = 1'b1;
      seq_ctr_d = seq_ctr_q + 8'd1;
      if (ack && state_q == ST_READY) begin
        // Ack and capture together: the new frame goes to the back bank, which becomes the front.
        wr_bank = ~fb_q;
        fb_d    = ~fb_q;
        state_d = ST_READY;
      end else begin
        case (st_a)
          ST_EMPTY: begin wr_bank = fb_a;  state_d = ST_READY;   end
          ST_READY: begin wr_bank = ~fb_a; state_d = ST_PENDING; end
          default:  begin wr_bank = ~fb_a; ovf = 1'b1;           end
        endcase
      end
    end

    if (clr) begin
      ovf_sticky_d = 1'b0;
      ovf_cnt_d    = 8'd0;
    end
    if (ovf) begin
      ovf_sticky_d = 1'b1;
      if (ovf_cnt_d != 8'hFF) ovf_cnt_d = ovf_cnt_d + 8'd1;
    end
  end

  // Zero-extended views of the front bank, used by the byte read mux.
  logic [31:0] cnt_ext;
  logic [7:0]  freq_ext [PEAKS];
  logic [23:0] amp_ext  [PEAKS];

  assign cnt_ext = 32'(cnt_q[fb_q]);

  for (genvar gi = 0; gi < PEAKS; gi++) begin : g_front
    assign freq_ext[gi] = 8'(freq_q[fb_q][gi]);
    assign amp_ext[gi]  = 24'(amp_q[fb_q][gi]);
  end

  always_comb begin
    rd_byte = 8'h00;
    case (address)
      8'hF0:   rd_byte = {5'b0, ovf_sticky_q, state_q == ST_PENDING, state_q != ST_EMPTY};
      8'hF1:   rd_byte = ovf_cnt_q;
      8'hF2:   rd_byte = seq_q[fb_q];
      8'hF8:   rd_byte = 8'h2A;
      8'hF9:   rd_byte = 8'h35;
      8'hFA:   rd_byte = 8'h54;
      8'hFB:   rd_byte = 8'h47;
      default: begin
        // Multi-byte fields are big-endian: the MSB is at the lowest address.
        for (int k = 0; k < 4; k++)
          if (address == 8'(k)) rd_byte = cnt_ext[8*(3-k) +: 8];
        for (int i = 0; i < PEAKS; i++) begin
          if (address == 8'(4 + i)) rd_byte = freq_ext[i];
          for (int j = 0; j < 3; j++)
            if (address == 8'(10 + 3*i + j)) rd_byte = amp_ext[i][8*(2-j) +: 8];
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_EMPTY;
      fb_q         <= 1'b0;
      seq_ctr_q    <= 8'd0;
      ovf_sticky_q <= 1'b0;
      ovf_cnt_q    <= 8'd0;
      readdata_q   <= 8'h00;
      irq_q        <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        cnt_q[b] <= '0;
        seq_q[b] <= 8'd0;
        for (int i = 0; i < PEAKS; i++) begin
          freq_q[b][i] <= '0;
          amp_q[b][i]  <= '0;
        end
      end
    end else begin
      state_q      <= state_d;
      fb_q         <= fb_d;
      seq_ctr_q    <= seq_ctr_d;
      ovf_sticky_q <= ovf_sticky_d;
      ovf_cnt_q    <= ovf_cnt_d;
      irq_q        <= (state_d != ST_EMPTY);
      if (chipselect && read) readdata_q <= rd_byte;
      if (wr_en) begin
        cnt_q[wr_bank] <= counter_in;
        seq_q[wr_bank] <= seq_ctr_q;
        for (int i = 0; i < PEAKS; i++) begin
          freq_q[wr_bank][i] <= freqs_in[i*FREQ_WIDTH +: FREQ_WIDTH];
          amp_q[wr_bank][i]  <= amplitudes_in[i*AMPL_WIDTH +: AMPL_WIDTH];
        end
      end
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_peaks_readout_bridge.sv
module tb_peaks_readout_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [31:0]  counter_in;
  logic [47:0]  freqs_in;
  logic [143:0] amplitudes_in;
  logic         chipselect, read, write;
  logic [7:0]   address, writedata;
  logic [7:0]   readdata;
  logic         irq;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  localparam logic [47:0]  FREQS = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  localparam logic [143:0] AMPS  = {24'h5A5B5C, 24'h444444, 24'h333333,
                                    24'h222222, 24'h111111, 24'hABCDEF};

  always #10 clk = ~clk;

  peaks_readout_bridge dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .counter_in(counter_in),
    .freqs_in(freqs_in), .amplitudes_in(amplitudes_in), .chipselect(chipselect),
    .read(read), .write(write), .address(address), .writedata(writedata),
    .readdata(readdata), .irq(irq)
  );

  // Drive one read strobe. readdata is sampled at the following negedge.
  task automatic bus_read(input logic [7:0] a);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic capture(input logic [31:0] cnt);
    @(negedge clk);
    valid_in = 1'b1; counter_in = cnt; freqs_in = FREQS; amplitudes_in = AMPS;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    logic [7:0] a[5] = '{8'h00, 8'hF0, 8'hF8, 8'hFB, 8'h30};
    logic [7:0] e[5] = '{8'h00, 8'h00, 8'h2A, 8'h47, 8'h00};
    logic [7:0] x;
    do_reset();
    n_vec++;
    if (readdata !== 8'h00) begin n_bad++; $display("FAIL reset_readdata got %02h exp 00", readdata); end
    n_vec++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b exp 0", irq); end
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(e[k]);
      bus_read(a[k]);
      x = exp_q.pop_front();
      n_vec++;
      if (readdata !== x) begin n_bad++; $display("FAIL reset_rd[%02h] got %02h exp %02h", a[k], readdata, x); end
      $display("reset     rd[%02h] = %02h", a[k], readdata);
    end
  endtask

  task automatic test_capture();
    logic [7:0] a[13] = '{8'h00, 8'h03, 8'h04, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D,
                          8'h19, 8'h1B, 8'h1C, 8'hF0, 8'hF2};
    logic [7:0] e[13] = '{8'h12, 8'h78, 8'h01, 8'h06, 8'hAB, 8'hCD, 8'hEF, 8'h11,
                          8'h5A, 8'h5C, 8'h00, 8'h01, 8'h00};
    logic [7:0] x;
    capture(32'h12345678);
    n_vec++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL capture_irq got %b exp 1", irq); end
    for (int k = 0; k < 13; k++) begin
      exp_q.push_back(e[k]);
      bus_read(a[k]);
      x = exp_q.pop_front();
      n_vec++;
      if (readdata !== x) begin n_bad++; $display("FAIL capture_rd[%02h] got %02h exp %02h", a[k], readdata, x); end
      $display("capture   rd[%02h] = %02h", a[k], readdata);
    end
  endtask

  // Read strobe held every cycle. Each result is popped one cycle after its strobe.
  task automatic test_back_to_back();
    logic [7:0] a[4] = '{8'h01, 8'h02, 8'h05, 8'hF9};
    logic [7:0] e[4] = '{8'h34, 8'h56, 8'h02, 8'h35};
    logic [7:0] x;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        x = exp_q.pop_front();
        n_vec++;
        if (readdata !== x) begin n_bad++; $display("FAIL b2b_rd[%02h] got %02h exp %02h", a[k-1], readdata, x); end
        $display("b2b       rd[%02h] = %02h", a[k-1], readdata);
      end
      chipselect = 1'b1; read = 1'b1; address = a[k];
      exp_q.push_back(e[k]);
    end
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
    x = exp_q.pop_front();
    n_vec++;
    if (readdata !== x) begin n_bad++; $display("FAIL b2b_rd[%02h] got %02h exp %02h", a[3], readdata, x); end
    $display("b2b       rd[%02h] = %02h", a[3], readdata);
  endtask

  task automatic test_overrun_ack();
    logic [7:0] a1[4] = '{8'hF0, 8'hF1, 8'hF2, 8'h00};
    logic [7:0] e1[4] = '{8'h07, 8'h01, 8'h00, 8'h12};
    logic [7:0] a2[3] = '{8'hF2, 8'hF0, 8'h00};
    logic [7:0] e2[3] = '{8'h02, 8'h05, 8'hDE};
    logic [7:0] a3[2] = '{8'hF0, 8'hF1};
    logic [7:0] e3[2] = '{8'h01, 8'h00};
    logic [7:0] x;
    capture(32'h0000AAAA);
    capture(32'hDEADBEEF);
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(e1[k]); bus_read(a1[k]); x = exp_q.pop_front(); n_vec++;
      if (readdata !== x) begin n_bad++; $display("FAIL ovf_rd[%02h] got %02h exp %02h", a1[k], readdata, x); end
      $display("overrun   rd[%02h] = %02h", a1[k], readdata);
    end
    bus_write(8'hFF, 8'h01);
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(e2[k]); bus_read(a2[k]); x = exp_q.pop_front(); n_vec++;
      if (readdata !== x) begin n_bad++; $display("FAIL ack_rd[%02h] got %02h exp %02h", a2[k], readdata, x); end
      $display("ack       rd[%02h] = %02h", a2[k], readdata);
    end
    n_vec++;
    if (irq !== 1'b1) begin n_bad++; $display("FAIL ack_irq got %b exp 1", irq); end
    bus_write(8'hFF, 8'h02);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(e3[k]); bus_read(a3[k]); x = exp_q.pop_front(); n_vec++;
      if (readdata !== x) begin n_bad++; $display("FAIL clr_rd[%02h] got %02h exp %02h", a3[k], readdata, x); end
      $display("clear     rd[%02h] = %02h", a3[k], readdata);
    end
  endtask

  task automatic test_ack_with_capture();
    logic [7:0] a1[3] = '{8'hF2, 8'hF0, 8'hF1};
    logic [7:0] e1[3] = '{8'h01, 8'h03, 8'h00};
    logic [7:0] a2[2] = '{8'hF2, 8'hF0};
    logic [7:0] e2[2] = '{8'h02, 8'h01};
    logic [7:0] x;
    do_reset();
    n_vec++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL ackcap_reset_irq got %b exp 0", irq); end
    capture(32'h1);
    capture(32'h2);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = 8'hFF; writedata = 8'h01;
    valid_in = 1'b1; counter_in = 32'h3;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0; valid_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(e1[k]); bus_read(a1[k]); x = exp_q.pop_front(); n_vec++;
      if (readdata !== x) begin n_bad++; $display("FAIL ackcap_rd[%02h] got %02h exp %02h", a1[k], readdata, x); end
      $display("ackcap    rd[%02h] = %02h", a1[k], readdata);
    end
    bus_write(8'hFF, 8'h01);
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(e2[k]); bus_read(a2[k]); x = exp_q.pop_front(); n_vec++;
      if (readdata !== x) begin n_bad++; $display("FAIL ackcap2_rd[%02h] got %02h exp %02h", a2[k], readdata, x); end
      $display("ackcap2   rd[%02h] = %02h", a2[k], readdata);
    end
  endtask

  task automatic test_saturate_and_reset();
    logic [7:0] a1[2] = '{8'hF1, 8'hF0};
    logic [7:0] e1[2] = '{8'hFF, 8'h07};
    logic [7:0] a2[4] = '{8'hF0, 8'hF1, 8'hF2, 8'h00};
    logic [7:0] x;
    for (int n = 0; n < 300; n++) capture(32'(n));
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(e1[k]); bus_read(a1[k]); x = exp_q.pop_front(); n_vec++;
      if (readdata !== x) begin n_bad++; $display("FAIL sat_rd[%02h] got %02h exp %02h", a1[k], readdata, x); end
      $display("saturate  rd[%02h] = %02h", a1[k], readdata);
    end
    // Reset lands on a read strobe and on a capture. Both must be dropped.
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = 8'hF1; reset = 1'b0; valid_in = 1'b1;
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0; reset = 1'b1; valid_in = 1'b0;
    n_vec++;
    if (readdata !== 8'h00) begin n_bad++; $display("FAIL midrst_readdata got %02h exp 00", readdata); end
    n_vec++;
    if (irq !== 1'b0) begin n_bad++; $display("FAIL midrst_irq got %b exp 0", irq); end
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(8'h00); bus_read(a2[k]); x = exp_q.pop_front(); n_vec++;
      if (readdata !== x) begin n_bad++; $display("FAIL midrst_rd[%02h] got %02h exp %02h", a2[k], readdata, x); end
      $display("midreset  rd[%02h] = %02h", a2[k], readdata);
    end
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; counter_in = '0; freqs_in = '0; amplitudes_in = '0;
    chipselect = 1'b0; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    test_reset();
    test_capture();
    test_back_to_back();
    test_overrun_ack();
    test_ack_with_capture();
    test_saturate_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
